// File: rtl/ntt_bf_scheduler.sv
// ntt_bf_scheduler: iterative 8-point Kyber NTT sequencer that time-shares one
// external pipelined butterfly. Coefficients are loaded serially, transformed
// in place over 3 stages of 4 butterflies, then streamed out in natural order.
// Optional sticky protocol checker on err: define NTT_SCHED_CHECK_EN.
module ntt_bf_scheduler #(
    parameter int W = 12,
    parameter int Q = 3329
) (
    input  logic         clk,
    input  logic         r,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         bf_valid_in,
    output logic [W-1:0] bf_a,
    output logic [W-1:0] bf_b,
    output logic [W-1:0] bf_twiddle,
    input  logic         bf_valid_out,
    input  logic [W-1:0] bf_u,
    input  logic [W-1:0] bf_v,
    output logic         busy,
    output logic         err
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [W-1:0] TW_ONE  = W'(1);
    localparam logic [W-1:0] TW_1729 = W'(1729);
    localparam logic [W-1:0] TW_749  = W'(749);
    localparam logic [W-1:0] TW_40   = W'(40);

    logic [1:0] state_reg, state_next;
    logic [2:0] ld_cnt_reg;
    logic [1:0] k_reg;
    logic [1:0] stage_reg;
    logic [2:0] res_cnt_reg, res_cnt_next;
    logic [2:0] out_cnt_reg;

    // Tag queue of destination slot pairs for in-flight butterflies
    logic [1:0] tq_wr_reg, tq_rd_reg;
    logic [2:0] tq_cnt_reg;
    logic [2:0] tq_i_mem [4];
    logic [2:0] tq_j_mem [4];

    logic [W-1:0] coef [8];

    logic [2:0]   iss_i, iss_j;
    logic [W-1:0] iss_tw;
    logic         is_issue, ld_fire, wb_fire, out_fire, stage_done;
    logic [2:0]   wb_i, wb_j;

    assign is_issue   = (state_reg == ST_ISSUE);
    assign ld_fire    = (state_reg == ST_LOAD) && in_valid;
    assign out_fire   = (state_reg == ST_OUT) && out_ready;
    // Results are only accepted while a stage is in flight and a tag exists;
    // anything else (e.g. stragglers after an abort) is dropped.
    assign wb_fire    = bf_valid_out && (tq_cnt_reg != 3'd0) &&
                        ((state_reg == ST_ISSUE) || (state_reg == ST_DRAIN));
    assign wb_i       = tq_i_mem[tq_rd_reg];
    assign wb_j       = tq_j_mem[tq_rd_reg];
    assign res_cnt_next = res_cnt_reg + {2'b00, wb_fire};
    // Stage barrier: leave DRAIN on the same edge as the 4th writeback
    assign stage_done = (state_reg == ST_DRAIN) && (res_cnt_next == 3'd4);

    // Operand slot pair and twiddle for the current (stage, k) issue slot
    always_comb begin
        iss_i  = 3'd0;
        iss_j  = 3'd0;
        iss_tw = TW_ONE;
        case (stage_reg)
            2'd0: begin
                iss_i = {1'b0, k_reg};
                iss_j = {1'b1, k_reg};
                case (k_reg)
                    2'd0:    iss_tw = TW_ONE;
                    2'd1:    iss_tw = TW_1729;
                    2'd2:    iss_tw = TW_749;
                    default: iss_tw = TW_40;
                endcase
            end
            2'd1: begin
                iss_i  = {k_reg[1], 1'b0, k_reg[0]};
                iss_j  = {k_reg[1], 1'b1, k_reg[0]};
                iss_tw = k_reg[0] ? TW_749 : TW_ONE;
            end
            default: begin
                iss_i = {k_reg, 1'b0};
                iss_j = {k_reg, 1'b1};
            end
        endcase
    end

    // Next-state logic for LOAD -> ISSUE <-> DRAIN -> OUT -> LOAD
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD:  if (ld_fire && ld_cnt_reg == 3'd7) state_next = ST_ISSUE;
            ST_ISSUE: if (k_reg == 2'd3) state_next = ST_DRAIN;
            ST_DRAIN: if (stage_done) state_next = (stage_reg == 2'd2) ? ST_OUT : ST_ISSUE;
            default:  if (out_fire && out_cnt_reg == 3'd7) state_next = ST_LOAD;
        endcase
    end

    // State, counters and tag-queue pointers; reset aborts any transform
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_reg   <= ST_LOAD;
            ld_cnt_reg  <= 3'd0;
            k_reg       <= 2'd0;
            stage_reg   <= 2'd0;
            res_cnt_reg <= 3'd0;
            out_cnt_reg <= 3'd0;
            tq_wr_reg   <= 2'd0;
            tq_rd_reg   <= 2'd0;
            tq_cnt_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            if (ld_fire) ld_cnt_reg <= ld_cnt_reg + 3'd1;
            if (is_issue) k_reg <= k_reg + 2'd1;
            if (stage_done) begin
                stage_reg   <= (stage_reg == 2'd2) ? 2'd0 : stage_reg + 2'd1;
                res_cnt_reg <= 3'd0;
            end else begin
                res_cnt_reg <= res_cnt_next;
            end
            if (out_fire) out_cnt_reg <= out_cnt_reg + 3'd1;
            if (is_issue) tq_wr_reg <= tq_wr_reg + 2'd1;
            if (wb_fire) tq_rd_reg <= tq_rd_reg + 2'd1;
            tq_cnt_reg <= tq_cnt_reg + {2'b00, is_issue} - {2'b00, wb_fire};
        end
    end

    // Record destination pair of each issued butterfly
    always_ff @(posedge clk) begin
        if (is_issue) begin
            tq_i_mem[tq_wr_reg] <= iss_i;
            tq_j_mem[tq_wr_reg] <= iss_j;
        end
    end

    // Coefficient slots: serial load, then in-place writeback (u -> i, v -> j)
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            logic [W-1:0] slot_reg;
            // One slot: load and writeback never coincide (different states)
            always_ff @(posedge clk) begin
                if (ld_fire && ld_cnt_reg == 3'(gi))
                    slot_reg <= in_data;
                else if (wb_fire && wb_i == 3'(gi))
                    slot_reg <= bf_u;
                else if (wb_fire && wb_j == 3'(gi))
                    slot_reg <= bf_v;
            end
            assign coef[gi] = slot_reg;
        end
    endgenerate

    assign in_ready    = (state_reg == ST_LOAD);
    assign busy        = (state_reg != ST_LOAD);
    assign bf_valid_in = is_issue;
    assign bf_a        = is_issue ? coef[iss_i] : '0;
    assign bf_b        = is_issue ? coef[iss_j] : '0;
    assign bf_twiddle  = is_issue ? iss_tw : '0;
    assign out_valid   = (state_reg == ST_OUT);
    assign out_data    = (state_reg == ST_OUT) ? coef[out_cnt_reg] : '0;
    assign out_last    = (state_reg == ST_OUT) && (out_cnt_reg == 3'd7);

`ifdef NTT_SCHED_CHECK_EN
    localparam logic [W-1:0] Q_W = W'(Q);
    logic err_reg;

    // Sticky error: orphan result, out-of-range input or butterfly result
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            err_reg <= 1'b0;
        end else if ((bf_valid_out && tq_cnt_reg == 3'd0) ||
                     (ld_fire && in_data >= Q_W) ||
                     (bf_valid_out && (bf_u >= Q_W || bf_v >= Q_W))) begin
            err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`else
    logic unused_q;
    assign unused_q = (Q != 0);
    assign err = 1'b0;
`endif

endmodule

// File: doc/ntt_bf_scheduler.md
# ntt_bf_scheduler

- Iterative sequencer for an 8-point Kyber NTT (q = 3329) that time-shares one pipelined butterfly unit instead of instantiating twelve.
- Accepts coefficients serially into an internal 8×12-bit buffer and issues the 12 butterflies (3 stages × 4) with the correct operand indices and twiddles.
- Writes results back in place and streams the transformed coefficients out in natural order.
- Produces the same results as the team's fully unrolled 8-point NTT, using one shared butterfly.

## Interface

Parameters:
- W, 12, coefficient width
- Q, 3329, modulus; used only by the optional checker

Ports:
- clk  in  1  clock, rising edge
- r  in  1  reset, asynchronous, active-low
- in_valid  in  1  input coefficient valid
- in_data  in  W  input coefficient, index order 0..7
- in_ready  out  1  buffer accepting input
- out_valid  out  1  output coefficient valid
- out_data  out  W  output coefficient, index order 0..7
- out_last  out  1  marks index 7
- out_ready  in  1  downstream accepts output
- bf_valid_in  out  1  butterfly issue strobe
- bf_a  out  W  butterfly upper operand
- bf_b  out  W  butterfly lower operand
- bf_twiddle  out  W  runtime twiddle for this issue
- bf_valid_out  in  1  butterfly result valid; in-order, fixed latency L ≥ 1
- bf_u  in  W  result a + w·b mod q
- bf_v  in  W  result a − w·b mod q
- busy  out  1  high outside LOAD
- err  out  1  sticky protocol error; see Configuration

## Operation

States are LOAD, ISSUE, DRAIN and OUT. Reset enters LOAD and clears the counters, the stage index and err. Buffer contents are don't-care after reset.

LOAD:
- in_ready = 1.
- Each in_valid & in_ready beat writes buf[ld_cnt], then ld_cnt increments.
- After the 8th beat, go to ISSUE with stage = 0.
- in_valid outside LOAD is ignored.

ISSUE:
- One butterfly per cycle, k = 0..3.
- bf_a = buf[i], bf_b = buf[j], bf_valid_in = 1.
- Stage 0: pairs (0,4), (1,5), (2,6), (3,7); twiddles 1, 1729, 749, 40.
- Stage 1: pairs (0,2), (1,3), (4,6), (5,7); twiddles 1, 749, 1, 749.
- Stage 2: pairs (0,1), (2,3), (4,5), (6,7); twiddles 1, 1, 1, 1.
- Issued destination pairs (i, j) are pushed into a 4-entry tag queue.
- After k = 3, go to DRAIN.

Writeback (active in ISSUE and DRAIN):
- On bf_valid_out, pop the tag queue, then write buf[i] = bf_u and buf[j] = bf_v.
- Writeback ports are separate from the issue read path.

DRAIN:
- Wait until 4 results of the current stage are written (res_cnt == 4).
- Stage barrier: the next stage is never issued before all 4 writebacks. This makes RAW hazards impossible.
- Then stage++ and return to ISSUE. After stage 2, go to OUT.

OUT:
- out_data = buf[out_cnt], out_valid = 1, out_last = (out_cnt == 7).
- out_cnt advances on out_valid & out_ready.
- After index 7 is accepted, return to LOAD.

Arithmetic:
- No arithmetic in this block. Values pass through unchanged, W bits.

## Timing

Reset values:
- in_ready = 1 (LOAD).
- All other outputs = 0: out_valid, out_last, out_data, bf_valid_in, bf_a, bf_b, bf_twiddle, busy, err.

Latency:
- LOAD: 8 accepted beats minimum, with no bubbles required.
- Per stage: 4 + L cycles. The first issue of the next stage is in the cycle after the 4th writeback edge.
- Compute total: 3·(4 + L) cycles from the first ISSUE cycle to the first OUT cycle.
- OUT: 8 cycles minimum. out_ready low holds out_data/out_valid stable, with no index skip.

Boundary conditions:
- A writeback and an issue in the same cycle are allowed. Within a stage, issue reads never target a slot that is pending writeback.
- r asserted mid-operation aborts immediately: back to LOAD, partial results discarded.
- bf_valid_out arriving after the abort is ignored.
- Back-to-back transforms: LOAD is re-entered in the cycle after the last OUT handshake.

## Configuration

NTT_SCHED_CHECK_EN

Defined:
- err sets, and stays set until r, on any of:
  - bf_valid_out while the tag queue is empty;
  - in_data ≥ Q on an accepted beat;
  - bf_u or bf_v ≥ Q.
- Datapath behaviour is unchanged.

Undefined:
- err is tied to 0 and the checker logic is absent.

## Test plan

1. Butterfly model with L = 2. Input [1,0,0,0,0,0,0,0] → output [1,1,1,1,1,1,1,1], out_last on the 8th beat, and 3·6 = 18 cycles from the first ISSUE to the first out_valid.
2. Input [0,0,0,0,1,0,0,0] → output [1,1,1,1,3328,3328,3328,3328].
3. Any input → the bf_twiddle sequence over the 12 issues is 1,1729,749,40,1,749,1,749,1,1,1,1, with pairs in the order listed in Operation.
4. out_ready toggled 1,0,0,1,… during OUT → every index 0..7 is delivered exactly once, and data is held while stalled.
5. Assert r during stage 1 DRAIN, then load all-zero input → output all 0, no stale data, err = 0.
6. With NTT_SCHED_CHECK_EN defined: inject a spurious bf_valid_out in LOAD → err = 1 until r. Also feed in_data = 3329 → err = 1.
